// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_pkg
// Description : Shared types and defaults for the byte-wide memory
//               strobe/ready initiator (memory_requester).
//               Contents: default byte-address width, default wait timeout,
//               byte/word types and the request FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_pkg;

  localparam int c_addr_w_default  = 12;
  localparam int c_timeout_default = 15;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    ISSUE     = 3'd2,
    WAIT_LOW  = 3'd3,
    WAIT_HIGH = 3'd4,
    DONE      = 3'd5
  } req_fsm_t;

endpackage
`default_nettype wire

// File: rtl/memory_requester.sv
`default_nettype none
// ============================================================================
// Module      : memory_requester
// Description : Initiator for the byte-wide memory strobe/ready protocol.
//               Accepts 1-4 byte little-endian read/write requests on a
//               valid/ready port and performs one memory access per byte.
//               Read bytes are assembled into a 32-bit word; write words are
//               split into bytes. A wait that exceeds TIMEOUT cycles aborts
//               the request with rsp_err=1.
// Ports       : aclk/aresetn         clock, async active-low reset
//               req_*                request port (valid/ready handshake)
//               rsp_valid/err/rdata  one-cycle completion pulse + data
//               mem_*                byte-wide memory strobe/ready interface
// Revision    : 1.0 - initial release
// ============================================================================
module memory_requester
  import memory_pkg::*;
#(
  parameter int ADDR_W  = c_addr_w_default,
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_enable,
  output logic              mem_write,
  output logic              mem_strobe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  // Last counter value that may still be spent waiting; the following cycle
  // would be wait cycle number TIMEOUT+1.
  localparam logic [3:0] c_tmo_last = 4'(TIMEOUT - 1);

  req_fsm_t          r_state;
  req_fsm_t          w_state_nxt;
  logic              r_live;        // low during reset and until the first edge after it
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [1:0]        r_idx;
  word_t             r_wdata;
  word_t             r_rdata;
  word_t             r_rsp_rdata;
  logic              r_rsp_err;
  logic [3:0]        r_tmo;

  logic              w_accept;
  logic              w_byte_done;
  logic              w_last;
  logic              w_timeout;
  word_t             w_rdata_merged;
  byte_t             w_wbyte;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and Moore outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_byte_done = 1'b0;
    w_timeout   = 1'b0;
    w_last      = (r_idx == r_size);
    req_ready   = 1'b0;
    mem_enable  = 1'b0;
    mem_write   = 1'b0;
    mem_strobe  = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;

    case (r_state)
      IDLE: begin
        req_ready = r_live;
        if (req_valid && r_live) begin
          w_accept    = 1'b1;
          w_state_nxt = ARM;
        end
      end
      ARM: begin
        // One cycle of enable ahead of the first strobe for the memory's
        // enable synchroniser.
        mem_enable  = 1'b1;
        mem_write   = r_write;
        w_state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_enable  = 1'b1;
        mem_write   = r_write;
        mem_strobe  = 1'b1;
        w_state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        mem_enable = 1'b1;
        mem_write  = r_write;
        if (!mem_ready) begin
          w_state_nxt = WAIT_HIGH;
        end else if (r_tmo == c_tmo_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      WAIT_HIGH: begin
        mem_enable = 1'b1;
        mem_write  = r_write;
        if (mem_ready) begin
          w_byte_done = 1'b1;
          w_state_nxt = w_last ? DONE : ISSUE;
        end else if (r_tmo == c_tmo_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        rsp_valid   = 1'b1;
        rsp_err     = r_rsp_err;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Read word with the byte currently returned by the memory merged in, so
  // the final byte lands in the response on the same edge it is captured.
  always_comb begin
    w_rdata_merged                 = r_rdata;
    w_rdata_merged[8*r_idx +: 8]   = mem_rdata;
  end

  assign w_wbyte   = r_wdata[8*r_idx +: 8];
  assign mem_addr  = r_addr + ADDR_W'(r_idx);   // wraps modulo 2**ADDR_W
  assign mem_wdata = w_wbyte;
  assign rsp_rdata = r_rsp_rdata;

  // --------------------------------------------------------------------------
  // Request latch, byte index, read assembly, response and wait timer
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_live      <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_size      <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_tmo       <= '0;
    end else begin
      r_live <= 1'b1;

      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_size  <= req_size;
        r_wdata <= req_wdata;
        r_idx   <= '0;
        r_rdata <= '0;   // bytes above the request size read back as zero
      end

      if (w_byte_done && !r_write) begin
        r_rdata <= w_rdata_merged;
      end
      if (w_byte_done && !w_last) begin
        r_idx <= r_idx + 2'd1;
      end

      // Only the wait states transition into DONE.
      if (w_state_nxt == DONE) begin
        r_rsp_err   <= w_timeout;
        r_rsp_rdata <= (w_timeout || r_write) ? '0 : w_rdata_merged;
      end

      // Timer restarts on every state change, so each wait state gets its
      // own budget; it only advances while sitting in a wait state.
      if (w_state_nxt != r_state) begin
        r_tmo <= '0;
      end else if (r_state == WAIT_LOW || r_state == WAIT_HIGH) begin
        r_tmo <= r_tmo + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_requester
// Description : Self-checking bench for memory_requester, paired with a
//               behavioural 4 kB byte memory (zero-filled) that drops ready
//               for three cycles after each strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_requester;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 15;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic              mem_enable;
  logic              mem_write;
  logic              mem_strobe;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  memory_requester #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .mem_enable (mem_enable),
    .mem_write  (mem_write),
    .mem_strobe (mem_strobe),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  // ---------------- behavioural memory ----------------
  logic [7:0] mem_arr [4096] = '{default: 8'h00};
  logic [7:0] m_rdata = 8'h00;
  logic       m_ready = 1'b1;
  int         m_busy  = 0;
  logic       tie_ready = 1'b0;   // emulates "no memory": ready stuck high

  assign mem_ready = tie_ready ? 1'b1 : m_ready;
  assign mem_rdata = tie_ready ? 8'h00 : m_rdata;

  always @(posedge aclk) begin
    if (mem_strobe && mem_enable && !tie_ready) begin
      if (mem_write) mem_arr[mem_addr] <= mem_wdata;
      else           m_rdata <= mem_arr[mem_addr];
      m_busy  <= 3;
      m_ready <= 1'b0;
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) m_ready <= 1'b1;
    end
  end

  // ---------------- strobe monitor ----------------
  logic [ADDR_W-1:0] sq_addr [$];
  logic [7:0]        sq_data [$];
  int                strobe_while_busy = 0;

  always @(posedge aclk) begin
    if (aresetn && mem_strobe) begin
      sq_addr.push_back(mem_addr);
      sq_data.push_back(mem_wdata);
      if (!mem_ready) strobe_while_busy++;
    end
  end

  // Issues one request from a point 1 time unit after a rising edge and
  // returns the cycle distance from the accept cycle to rsp_valid.
  task automatic do_req(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [1:0] size, input logic [31:0] wd,
                        output int lat, output logic err,
                        output logic [31:0] rd, output logic en_done);
    int k;
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_size  = size; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 50) begin
      @(posedge aclk); #1; k++;
    end
    @(posedge aclk); #1;
    req_valid = 1'b0;
    req_addr  = '1;              // fields must not matter after accept
    req_wdata = 32'h5A5A5A5A;
    lat = -1; err = 1'bx; rd = 32'hxxxxxxxx; en_done = 1'bx;
    for (int i = 1; i <= 60; i++) begin
      if (rsp_valid) begin
        lat = i; err = rsp_err; rd = rsp_rdata; en_done = mem_enable;
        break;
      end
      @(posedge aclk); #1;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_size = '0; req_wdata = '0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_enable, mem_write, mem_strobe} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {req_ready, rsp_valid, rsp_err, mem_enable, mem_write, mem_strobe});
    end
    checks++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0", rsp_rdata, mem_addr, mem_wdata);
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after_edge: got %b want 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    int lat; logic err; logic [31:0] rd; logic en;
    sq_addr.delete(); sq_data.delete();
    do_req(1'b1, 12'h100, 2'd3, 32'hDEADBEEF, lat, err, rd, en);
    checks++;
    if (lat !== 22 || err !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL write4_rsp: lat=%0d err=%b rdata=%h want lat=22 err=0 rdata=0", lat, err, rd);
    end
    checks++;
    if (sq_addr.size() !== 4 || {sq_addr[3], sq_addr[2], sq_addr[1], sq_addr[0]} !== 48'h103_102_101_100) begin
      errors++;
      $display("FAIL write4_addrs: n=%0d got %h %h %h %h want 100 101 102 103",
               sq_addr.size(), sq_addr[0], sq_addr[1], sq_addr[2], sq_addr[3]);
    end
    checks++;
    if ({sq_data[3], sq_data[2], sq_data[1], sq_data[0]} !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write4_bytes: got %h want deadbeef",
               {sq_data[3], sq_data[2], sq_data[1], sq_data[0]});
    end

    do_req(1'b0, 12'h100, 2'd3, 32'h0, lat, err, rd, en);
    checks++;
    if (lat !== 22 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read4: lat=%0d err=%b rdata=%h want lat=22 err=0 rdata=deadbeef", lat, err, rd);
    end
    repeat (3) begin @(posedge aclk); #1; end
    checks++;
    if (rsp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rdata_hold: got %h want deadbeef", rsp_rdata);
    end

    do_req(1'b0, 12'h101, 2'd0, 32'h0, lat, err, rd, en);
    checks++;
    if (lat !== 7 || err !== 1'b0 || rd !== 32'h000000BE) begin
      errors++;
      $display("FAIL read1: lat=%0d err=%b rdata=%h want lat=7 err=0 rdata=000000be", lat, err, rd);
    end
  endtask

  task automatic test_wrap();
    int lat; logic err; logic [31:0] rd; logic en;
    sq_addr.delete(); sq_data.delete();
    do_req(1'b1, 12'hFFE, 2'd3, 32'h44332211, lat, err, rd, en);
    checks++;
    if (sq_addr.size() !== 4 || {sq_addr[0], sq_addr[1], sq_addr[2], sq_addr[3]} !== 48'hFFE_FFF_000_001) begin
      errors++;
      $display("FAIL wrap_addrs: n=%0d got %h %h %h %h want ffe fff 000 001",
               sq_addr.size(), sq_addr[0], sq_addr[1], sq_addr[2], sq_addr[3]);
    end
    do_req(1'b0, 12'h000, 2'd1, 32'h0, lat, err, rd, en);
    checks++;
    if (lat !== 12 || rd !== 32'h00004433) begin
      errors++;
      $display("FAIL wrap_read2: lat=%0d rdata=%h want lat=12 rdata=00004433", lat, rd);
    end
  endtask

  task automatic test_timeout();
    int lat; logic err; logic [31:0] rd; logic en;
    tie_ready = 1'b1;
    sq_addr.delete(); sq_data.delete();
    do_req(1'b0, 12'h100, 2'd2, 32'h0, lat, err, rd, en);
    checks++;
    if (lat !== 3 + TIMEOUT || err !== 1'b1 || rd !== 32'h0 || en !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rsp: lat=%0d err=%b rdata=%h en=%b want lat=%0d err=1 rdata=0 en=0",
               lat, err, rd, en, 3 + TIMEOUT);
    end
    checks++;
    if (sq_addr.size() !== 1) begin
      errors++;
      $display("FAIL timeout_strobes: got %0d want 1", sq_addr.size());
    end
    tie_ready = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_back_to_back();
    int k; int first_lat; int second_acc; int lat;
    logic [31:0] first_rd; logic [31:0] rd;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h100; req_size = 2'd0;
    k = 0;
    while (!req_ready && k < 50) begin @(posedge aclk); #1; k++; end
    @(posedge aclk); #1;
    req_addr = 12'h102; req_size = 2'd1;    // second request, valid stays high
    first_lat = -1; second_acc = -1; first_rd = 32'hxxxxxxxx;
    for (int i = 1; i <= 40; i++) begin
      if (rsp_valid && first_lat < 0) begin first_lat = i; first_rd = rsp_rdata; end
      if (req_ready) begin second_acc = i; break; end
      @(posedge aclk); #1;
    end
    checks++;
    if (first_lat !== 7 || first_rd !== 32'h000000EF) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d rdata=%h want lat=7 rdata=000000ef", first_lat, first_rd);
    end
    checks++;
    if (second_acc !== 8) begin
      errors++;
      $display("FAIL b2b_accept: cycle=%0d want 8", second_acc);
    end
    @(posedge aclk); #1;
    req_valid = 1'b0;
    lat = -1; rd = 32'hxxxxxxxx;
    for (int i = 1; i <= 40; i++) begin
      if (rsp_valid) begin lat = i; rd = rsp_rdata; break; end
      @(posedge aclk); #1;
    end
    checks++;
    if (lat !== 12 || rd !== 32'h0000DEAD) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d rdata=%h want lat=12 rdata=0000dead", lat, rd);
    end
    checks++;
    if (strobe_while_busy !== 0) begin
      errors++;
      $display("FAIL strobe_while_not_ready: got %0d want 0", strobe_while_busy);
    end
  endtask

  task automatic test_reset_mid_write();
    int k; int nrsp; int lat; logic err; logic [31:0] rd; logic en;
    sq_addr.delete(); sq_data.delete();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h200;
    req_size = 2'd3; req_wdata = 32'hAABBCCDD;
    k = 0;
    while (!req_ready && k < 50) begin @(posedge aclk); #1; k++; end
    @(posedge aclk); #1;
    req_valid = 1'b0;
    repeat (12) begin @(posedge aclk); #1; end   // WAIT_LOW of byte 2
    checks++;
    if (sq_addr.size() !== 3) begin
      errors++;
      $display("FAIL rstmid_strobes: got %0d want 3", sq_addr.size());
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, mem_enable, mem_write, mem_strobe} !== 5'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: ctrl=%b addr=%h want 00000 addr=0",
               {req_ready, rsp_valid, mem_enable, mem_write, mem_strobe}, mem_addr);
    end
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;
    nrsp = 0;
    repeat (30) begin @(posedge aclk); #1; if (rsp_valid) nrsp++; end
    checks++;
    if (nrsp !== 0) begin
      errors++;
      $display("FAIL rstmid_no_rsp: got %0d responses want 0", nrsp);
    end
    do_req(1'b0, 12'h200, 2'd3, 32'h0, lat, err, rd, en);
    checks++;
    if (lat !== 22 || err !== 1'b0 || rd !== 32'h00BBCCDD) begin
      errors++;
      $display("FAIL rstmid_next_read: lat=%0d err=%b rdata=%h want lat=22 err=0 rdata=00bbccdd",
               lat, err, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_timeout();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
